frv_asi_issue: RTL
==================

Name: frv_asi_issue

Overview:
Issue and retire buffer that sits directly upstream of frv_asi in the execute path.
- Accepts one algorithm-specific instruction at a time from the dispatch stage over a valid/ready handshake.
- Holds the uop and operands stable on the asi_* bus until frv_asi signals ready, which covers multi-cycle AES variants.
- Captures asi_result into an output register for the writeback stage, and records a per-instruction latency count for constant-time checks.

Parameters:
XLEN, 32, datapath width; XL = XLEN-1.
UOP_W, 7, width of the ASI micro-op field; OP = UOP_W-1, matching the frv_asi uop field width.
CNT_W, 8, width of the saturating latency counter.

Ports:
g_clk  in  1  global clock
g_resetn  in  1  asynchronous active-low reset
s_valid  in  1  dispatch has an ASI instruction
s_ready  out  1  block accepts the instruction this cycle
s_uop  in  UOP_W  micro-op
s_rs1  in  XLEN  source operand 1
s_rs2  in  XLEN  source operand 2
s_shamt  in  2  shift amount / byte select
s_rd  in  5  destination register index
flush  in  1  pipeline flush (squash in-flight op)
asi_valid  out  1  to frv_asi
asi_ready  in  1  from frv_asi
asi_flush  out  1  to frv_asi, single-cycle flush pulse
asi_uop  out  UOP_W  registered uop
asi_rs1  out  XLEN  registered rs1
asi_rs2  out  XLEN  registered rs2
asi_shamt  out  2  registered shamt
asi_result  in  XLEN  from frv_asi
m_valid  out  1  result available to writeback
m_ready  in  1  writeback consumes the result
m_rd  out  5  destination index
m_result  out  XLEN  captured result
m_cycles  out  CNT_W  cycles the op spent in ISSUE, saturating

Behaviour:
- Reset (asynchronous, g_resetn low): state=IDLE; all registers zero.
  - Outputs: asi_valid=0, asi_flush=0, m_valid=0, m_result=0, m_rd=0, m_cycles=0; asi_* operand outputs=0.
- States:
  - IDLE: no op held.
  - ISSUE: op presented to frv_asi.
  - DONE: result held for writeback.
- s_ready = !flush && (IDLE || (DONE && m_ready)).
- Accept: s_valid && s_ready.
  - Registers uop/rs1/rs2/shamt/rd.
  - Next state = ISSUE; counter cleared to 1.
- ISSUE:
  - asi_valid=1; operands held stable.
  - asi_ready=1: capture asi_result into m_result, counter value into m_cycles, rd into m_rd; next state = DONE.
  - Otherwise: counter increments, saturating at 2^CNT_W-1.
- asi_ready is ignored outside ISSUE.
- DONE:
  - m_valid=1.
  - m_ready && accept: go to ISSUE with the new op. Back-to-back issue has zero bubble.
  - m_ready without accept: go to IDLE.
  - m_ready=0: hold all values.
- Latency: op accepted at edge N; asi_valid high from cycle N+1. For a single-cycle frv_asi op, m_valid is high from N+2.
- Throughput: one op every 2 cycles for single-cycle ops.
- Operands are zeroed when returning to IDLE, so no stale secrets are left on the asi bus.
- flush:
  - Takes priority over accept and asi_ready.
  - Next state = IDLE; m_valid and asi_valid deassert the next cycle; operand registers are zeroed.
  - asi_flush=1 in the cycle after flush is sampled, only if the state was ISSUE.
  - A result in DONE is discarded.
- Simultaneous m_ready and flush in DONE: the flush wins and the result is dropped; writeback must gate m_ready with its own flush.
- m_cycles:
  - Value is 1 for an op ready in its first ISSUE cycle.
  - Saturates rather than wrapping.
  - Valid only while m_valid=1.

Decomposition:
- ASI uop constants (ASI_AES, ASI_SHA2, ASI_SHA3, per-variant uops) stay in the shared frv_common.vh include.
- State encoding (IDLE=2'd0, ISSUE=2'd1, DONE=2'd2) is local to this block.
- No sub-module: the counter and FSM fit in one module; 2'd3 is unreachable and decodes as IDLE.

Test Plan:
- Single SHA2 op: s_valid with uop=ASI_SHA256_S0, rs1=0x6a09e667, asi_ready tied to asi_valid -> m_valid at N+2, m_result equals asi_result, m_cycles=1, m_rd matches s_rd.
- Multi-cycle AES: asi_ready held low 4 cycles -> asi_rs1/rs2/uop stable for all 5 ISSUE cycles, m_cycles=5, s_ready=0 throughout.
- Back-to-back with m_ready=1: two consecutive ops -> second accepted in the DONE cycle of the first, no IDLE cycle between them.
- Writeback stall: m_ready=0 for 3 cycles in DONE -> m_result/m_rd/m_cycles unchanged, s_ready=0; release -> IDLE.
- Flush in ISSUE: flush pulse while asi_ready=0 -> asi_flush pulse 1 cycle, state IDLE, m_valid never asserts, asi_rs1=0; flush with s_valid in IDLE -> op not accepted.
- Saturation and reset: asi_ready low 300 cycles with CNT_W=8 -> m_cycles=255; g_resetn low mid-ISSUE asynchronously -> asi_valid=0 immediately, all outputs zero.

Source files
------------

// File: rtl/frv_asi_issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : frv_asi_issue_pkg
//  Description : Shared field widths for the ASI issue/retire buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package frv_asi_issue_pkg;

  // Destination register index width (architectural register file of 32).
  localparam int c_RD_W    = 5;

  // Shift amount / byte select field carried alongside the ASI uop.
  localparam int c_SHAMT_W = 2;

endpackage : frv_asi_issue_pkg
`default_nettype wire

// File: rtl/frv_asi_issue.sv
`default_nettype none
// ============================================================================
//  Module      : frv_asi_issue
//  Description : Issue and retire buffer in front of frv_asi. Holds one
//                algorithm-specific op stable on the asi_* bus until frv_asi
//                is ready, captures the result for writeback and records how
//                many cycles the op spent in ISSUE (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module frv_asi_issue
  import frv_asi_issue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int UOP_W = 7,
  parameter int CNT_W = 8
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  // dispatch side
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [UOP_W-1:0]     s_uop,
  input  logic [XLEN-1:0]      s_rs1,
  input  logic [XLEN-1:0]      s_rs2,
  input  logic [c_SHAMT_W-1:0] s_shamt,
  input  logic [c_RD_W-1:0]    s_rd,
  input  logic                 flush,
  // frv_asi side
  output logic                 asi_valid,
  input  logic                 asi_ready,
  output logic                 asi_flush,
  output logic [UOP_W-1:0]     asi_uop,
  output logic [XLEN-1:0]      asi_rs1,
  output logic [XLEN-1:0]      asi_rs2,
  output logic [c_SHAMT_W-1:0] asi_shamt,
  input  logic [XLEN-1:0]      asi_result,
  // writeback side
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [c_RD_W-1:0]    m_rd,
  output logic [XLEN-1:0]      m_result,
  output logic [CNT_W-1:0]     m_cycles
);

  // State encoding; 2'd3 is unreachable and is treated as IDLE.
  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_in_issue;
  logic                 w_in_done;
  logic                 w_in_idle;
  logic                 w_accept;

  logic [UOP_W-1:0]     r_uop;
  logic [XLEN-1:0]      r_rs1;
  logic [XLEN-1:0]      r_rs2;
  logic [c_SHAMT_W-1:0] r_shamt;
  logic [c_RD_W-1:0]    r_rd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_asi_flush;
  logic [c_RD_W-1:0]    r_m_rd;
  logic [XLEN-1:0]      r_m_result;
  logic [CNT_W-1:0]     r_m_cycles;

  // Decode the state register into one-hot style qualifiers.
  always_comb begin
    w_in_issue = (r_state == c_ST_ISSUE);
    w_in_done  = (r_state == c_ST_DONE);
    w_in_idle  = !w_in_issue && !w_in_done;
  end

  // State register.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; flush overrides everything else.
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = c_ST_IDLE;
    end else if (w_in_issue) begin
      w_state_nxt = asi_ready ? c_ST_DONE : c_ST_ISSUE;
    end else if (w_in_done) begin
      if (m_ready) begin
        w_state_nxt = w_accept ? c_ST_ISSUE : c_ST_IDLE;
      end
    end else begin
      w_state_nxt = w_accept ? c_ST_ISSUE : c_ST_IDLE;
    end
  end

  // Handshake and valid outputs decoded from the current state.
  always_comb begin
    s_ready   = !flush && (w_in_idle || (w_in_done && m_ready));
    w_accept  = s_valid && s_ready;
    asi_valid = w_in_issue;
    m_valid   = w_in_done;
  end

  // Operand, latency counter and result registers. Operands are cleared on
  // flush and on the DONE->IDLE return so no secret stays on the asi bus.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_uop       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_shamt     <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_asi_flush <= 1'b0;
      r_m_rd      <= '0;
      r_m_result  <= '0;
      r_m_cycles  <= '0;
    end else if (flush) begin
      r_uop       <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_shamt     <= '0;
      r_rd        <= '0;
      r_cnt       <= '0;
      r_asi_flush <= w_in_issue;
      r_m_rd      <= '0;
      r_m_result  <= '0;
      r_m_cycles  <= '0;
    end else begin
      r_asi_flush <= 1'b0;
      if (w_accept) begin
        r_uop   <= s_uop;
        r_rs1   <= s_rs1;
        r_rs2   <= s_rs2;
        r_shamt <= s_shamt;
        r_rd    <= s_rd;
        r_cnt   <= c_CNT_ONE;
      end else if (w_in_done && m_ready) begin
        r_uop   <= '0;
        r_rs1   <= '0;
        r_rs2   <= '0;
        r_shamt <= '0;
        r_rd    <= '0;
      end
      if (w_in_issue) begin
        if (asi_ready) begin
          r_m_result <= asi_result;
          r_m_cycles <= r_cnt;
          r_m_rd     <= r_rd;
        end else if (r_cnt != c_CNT_MAX) begin
          r_cnt <= r_cnt + c_CNT_ONE;
        end
      end
    end
  end

  assign asi_flush = r_asi_flush;
  assign asi_uop   = r_uop;
  assign asi_rs1   = r_rs1;
  assign asi_rs2   = r_rs2;
  assign asi_shamt = r_shamt;
  assign m_rd      = r_m_rd;
  assign m_result  = r_m_result;
  assign m_cycles  = r_m_cycles;

endmodule : frv_asi_issue
`default_nettype wire
